// File: rtl/machine_seq_ctrl.sv
// Test sequencer for single-input/single-output machine_* FSMs: resets the FSM,
// drives a captured bit pattern on x, records F after each bit and grades the F count.
//
// state   | meaning
// IDLE    | waiting for start; last results held
// DUT_RST | one-cycle reset pulse to the attached FSM
// DRIVE   | drive pattern[idx]; capture F produced by the previous bit
// LAST    | capture F produced by the final bit
// DONE    | one-cycle done pulse; pass updated at end of cycle
module machine_seq_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [CNT_W-1:0]   length,
  input  logic [CNT_W-1:0]   expected_count,
  input  logic               dut_f,
  output logic               dut_x,
  output logic               dut_rst,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [CNT_W-1:0]   f_count,
  output logic [MAX_LEN-1:0] f_trace
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DUT_RST,
    S_DRIVE,
    S_LAST,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [CNT_W-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   f_count_q, f_count_d;
  logic [MAX_LEN-1:0] f_trace_q, f_trace_d;
  logic               pass_q, pass_d;
  logic [CNT_W-1:0]   f_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      len_q     <= '0;
      exp_q     <= '0;
      idx_q     <= '0;
      f_count_q <= '0;
      f_trace_q <= '0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      exp_q     <= exp_d;
      idx_q     <= idx_d;
      f_count_q <= f_count_d;
      f_trace_q <= f_trace_d;
      pass_q    <= pass_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    exp_d     = exp_q;
    idx_d     = idx_q;
    f_count_d = f_count_q;
    f_trace_d = f_trace_q;
    pass_d    = pass_q;
    f_inc     = {{(CNT_W-1){1'b0}}, dut_f};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pattern_d = pattern;
          len_d     = (length > MAX_LEN_C) ? MAX_LEN_C : length;
          exp_d     = expected_count;
          f_count_d = '0;
          f_trace_d = '0;
          pass_d    = 1'b0;
          state_d   = S_DUT_RST;
        end
      end
      S_DUT_RST: begin
        idx_d   = '0;
        state_d = (len_q != '0) ? S_DRIVE : S_LAST;
      end
      S_DRIVE: begin
        // dut_f here reflects the bit driven in the previous DRIVE cycle
        if (idx_q != '0) begin
          f_trace_d[IDX_W'(idx_q - 1'b1)] = dut_f;
          f_count_d = f_count_q + f_inc;
        end
        if (idx_q == len_q - 1'b1) begin
          state_d = S_LAST;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_LAST: begin
        if (len_q != '0) begin
          f_trace_d[IDX_W'(len_q - 1'b1)] = dut_f;
          f_count_d = f_count_q + f_inc;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        pass_d  = (f_count_q == exp_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign dut_rst = rst | (state_q == S_DUT_RST);
  assign dut_x   = (state_q == S_DRIVE) & pattern_q[idx_q[IDX_W-1:0]];
  assign pass    = pass_q;
  assign f_count = f_count_q;
  assign f_trace = f_trace_q;

endmodule

// File: tb/tb_machine_seq_ctrl.sv
// Bench for machine_seq_ctrl: drives runs against either a delay-register stub
// or a Moore "101" detector standing in for an attached machine_* FSM.
module tb_machine_seq_ctrl;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 5;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [MAX_LEN-1:0] pattern;
  logic [CNT_W-1:0]   length;
  logic [CNT_W-1:0]   expected_count;
  logic               dut_f;
  logic               dut_x;
  logic               dut_rst;
  logic               busy;
  logic               done;
  logic               pass;
  logic [CNT_W-1:0]   f_count;
  logic [MAX_LEN-1:0] f_trace;

  int   total = 0;
  int   bad   = 0;
  logic use_fsm = 1'b0;
  logic stub_q;
  logic [2:0] hist_q;

  machine_seq_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .length(length),
    .expected_count(expected_count), .dut_f(dut_f), .dut_x(dut_x),
    .dut_rst(dut_rst), .busy(busy), .done(done), .pass(pass),
    .f_count(f_count), .f_trace(f_trace)
  );

  always #5 clk = ~clk;

  // stub: F is x delayed one clock; detector: F=1 when the last three bits were 1,0,1
  always_ff @(posedge clk) begin
    if (dut_rst) begin
      stub_q <= 1'b0;
      hist_q <= 3'b000;
    end else begin
      stub_q <= dut_x;
      hist_q <= {hist_q[1:0], dut_x};
    end
  end
  assign dut_f = use_fsm ? (hist_q == 3'b101) : stub_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic model_f(input logic [15:0] pat, input int k, input logic fsm);
    logic [15:0] s;
    if (!fsm) begin
      s = pat >> k;
      return s[0];
    end
    if (k < 2) return 1'b0;
    s = pat >> (k - 2);
    return (s[2:0] == 3'b101);
  endfunction

  task automatic run(input logic [15:0] pat, input logic [4:0] len_in, input logic [4:0] exp_cnt,
                     input logic fsm, input bit noise, input string tag);
    int len, cnt, cyc;
    logic [15:0] tr, sh;
    logic want_x;
    bit seen;
    len = (len_in > 5'd16) ? 16 : int'(len_in);
    tr  = '0;
    cnt = 0;
    for (int k = 0; k < len; k++) begin
      if (model_f(pat, k, fsm)) begin
        tr = tr | (16'd1 << k);
        cnt++;
      end
    end
    use_fsm = fsm;
    pattern = pat;
    length = len_in;
    expected_count = exp_cnt;
    start = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pattern = 16'($urandom);
      length = 5'($urandom);
      expected_count = 5'($urandom);
      if (cyc >= 2 && cyc <= len + 1) begin
        sh = pat >> (cyc - 2);
        want_x = sh[0];
      end else begin
        want_x = 1'b0;
      end
      chk({tag, "_busy"}, 32'(busy), 32'(1));
      chk({tag, "_dut_rst"}, 32'(dut_rst), 32'(cyc == 1));
      chk({tag, "_dut_x"}, 32'(dut_x), 32'(want_x));
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(cyc), 32'(len + 3));
    chk({tag, "_f_count"}, 32'(f_count), 32'(cnt));
    chk({tag, "_f_trace"}, 32'(f_trace), 32'(tr));
    @(negedge clk);
    chk({tag, "_pass"}, 32'(pass), 32'(cnt == int'(exp_cnt)));
    chk({tag, "_idle_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done_pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    logic [15:0] rp;
    logic [4:0]  rl, re;
    int rlen, rcnt;
    logic rf;
    rst = 1'b1;
    start = 1'b0;
    pattern = '0;
    length = '0;
    expected_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_pass", 32'(pass), 32'(0));
    chk("rst_dut_x", 32'(dut_x), 32'(0));
    chk("rst_f_count", 32'(f_count), 32'(0));
    chk("rst_f_trace", 32'(f_trace), 32'(0));
    chk("rst_dut_rst", 32'(dut_rst), 32'(1));
    rst = 1'b0;
    #1;
    chk("rel_dut_rst", 32'(dut_rst), 32'(0));
    @(negedge clk);

    run(16'h00F5, 5'd8, 5'd6, 1'b0, 1'b0, "normal");
    chk("normal_pass_hand", 32'(pass), 32'(1));
    run(16'h0003, 5'd4, 5'd3, 1'b0, 1'b0, "mismatch");
    chk("mismatch_cnt_hand", 32'(f_count), 32'(2));
    run(16'h0000, 5'd0, 5'd0, 1'b0, 1'b0, "len0");
    run(16'hFFFF, 5'd20, 5'd16, 1'b0, 1'b0, "clamp");
    chk("clamp_cnt_hand", 32'(f_count), 32'(16));
    run(16'h0A5C, 5'd10, 5'd5, 1'b0, 1'b1, "noisy");
    run(16'h00B5, 5'd8, 5'd3, 1'b1, 1'b0, "fsm");
    chk("fsm_trace_hand", 32'(f_trace), 32'h0094);
    chk("fsm_pass_hand", 32'(pass), 32'(1));

    for (int n = 0; n < 30; n++) begin
      rp = 16'($urandom);
      rl = 5'($urandom_range(0, 20));
      rf = 1'($urandom_range(0, 1));
      rlen = (rl > 5'd16) ? 16 : int'(rl);
      rcnt = 0;
      for (int k = 0; k < rlen; k++) rcnt += int'(model_f(rp, k, rf));
      re = ($urandom_range(0, 1) == 1) ? 5'(rcnt) : 5'($urandom_range(0, 16));
      run(rp, rl, re, rf, bit'($urandom_range(0, 1)), "rand");
    end

    // abort in DRIVE at index 3 of a length-8 run
    use_fsm = 1'b0;
    pattern = 16'h00FF;
    length = 5'd8;
    expected_count = 5'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_cnt", 32'(f_count), 32'(2));
    chk("abort_pre_x", 32'(dut_x), 32'(1));
    rst = 1'b1;
    #1;
    chk("abort_dut_rst", 32'(dut_rst), 32'(1));
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_f_count", 32'(f_count), 32'(0));
    chk("abort_f_trace", 32'(f_trace), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_hold_rst", 32'(dut_rst), 32'(1));
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 14; n++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'(0));
      chk("abort_idle", 32'(busy), 32'(0));
    end
    run(16'h1234, 5'd12, 5'd5, 1'b0, 1'b0, "recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
